// File: rtl/game_ctrl.sv
// Game supervisor: BCD score, breach detect (alive & y>=BOTTOM_Y), IDLE/PLAY/OVER FSM.
// Optional best-score tracking with new-record flag when HI_SCORE_EN is defined.
module game_ctrl #(
  parameter int N_ENEMY  = 8,
  parameter int BOTTOM_Y = 440,
  parameter int DIGITS   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  killed,
  input  logic [N_ENEMY-1:0]    enemy_alive,
  input  logic [8:0]            enemy_y [0:N_ENEMY-1],
  output logic                  gameover,
  output logic                  playing,
  output logic [4*DIGITS-1:0]   score,
  output logic [4*DIGITS-1:0]   hi_score,
  output logic                  new_record
);

  localparam int SW = 4*DIGITS;
  localparam logic [8:0] BOTTOM = 9'(BOTTOM_Y);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;

  state_t        ps, ns;
  logic          breach_d, breach_q;
  logic          enter_play;
  logic [SW-1:0] score_inc, score_nx;

  // Saturating BCD increment: all-nines input comes back unchanged.
  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (v[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    if (carry) r = v;
    return r;
  endfunction

  always_comb begin
    breach_d = 1'b0;
    for (int i = 0; i < N_ENEMY; i++) begin
      if (enemy_alive[i] && (enemy_y[i] >= BOTTOM)) breach_d = 1'b1;
    end
  end

  always_comb begin
    ns = ps;
    case (ps)
      S_IDLE:  if (start)    ns = S_PLAY;
      S_PLAY:  if (breach_q) ns = S_OVER;
      S_OVER:  if (start)    ns = S_PLAY;
      default: ns = S_IDLE;
    endcase
  end

  assign enter_play = (ns == S_PLAY) && (ps != S_PLAY);
  assign score_inc  = bcd_inc(score);
  // Final score on this edge, including a kill that coincides with the breach.
  assign score_nx   = (ps == S_PLAY && killed) ? score_inc : score;

  always_ff @(posedge clk) begin
    if (reset) begin
      ps       <= S_IDLE;
      score    <= '0;
      breach_q <= 1'b0;
    end else begin
      ps       <= ns;
      // Heights are stale while enemies re-initialises; mask on the entry edge.
      breach_q <= enter_play ? 1'b0 : breach_d;
      if (enter_play) score <= '0;
      else            score <= score_nx;
    end
  end

  assign gameover = (ps == S_OVER);
  assign playing  = (ps == S_PLAY);

`ifdef HI_SCORE_EN
  logic [SW-1:0] hi_q;
  logic          rec_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q  <= '0;
      rec_q <= 1'b0;
    end else if (ps == S_PLAY && ns == S_OVER) begin
      if (score_nx > hi_q) begin
        hi_q  <= score_nx;
        rec_q <= 1'b1;
      end
    end else if (enter_play) begin
      rec_q <= 1'b0;
    end
  end

  assign hi_score   = hi_q;
  assign new_record = rec_q;
`else
  assign hi_score   = '0;
  assign new_record = 1'b0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: expectations queued as stimulus is driven, checked at negedge.
module tb_game_ctrl;

`ifdef HI_SCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  localparam int SIG_SCORE = 0, SIG_HI = 1, SIG_OVER = 2, SIG_PLAY = 3, SIG_REC = 4;

  logic        clk = 1'b0;
  logic        reset, start, killed;
  logic [7:0]  enemy_alive;
  logic [8:0]  enemy_y [0:7];
  logic        gameover, playing, new_record;
  logic [15:0] score, hi_score;

  int n_vec  = 0;
  int n_fail = 0;
  int m_score = 0;

  string       q_tag [$];
  int          q_sig [$];
  logic [15:0] q_exp [$];

  game_ctrl #(.N_ENEMY(8), .BOTTOM_Y(440), .DIGITS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .killed(killed),
    .enemy_alive(enemy_alive), .enemy_y(enemy_y),
    .gameover(gameover), .playing(playing), .score(score),
    .hi_score(hi_score), .new_record(new_record)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          x;
    x = (v > 9999) ? 9999 : v;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] observe(input int sig);
    case (sig)
      SIG_SCORE: return score;
      SIG_HI:    return hi_score;
      SIG_OVER:  return {15'd0, gameover};
      SIG_PLAY:  return {15'd0, playing};
      default:   return {15'd0, new_record};
    endcase
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input string tag, input int sig, input logic [15:0] exp);
    q_tag.push_back(tag);
    q_sig.push_back(sig);
    q_exp.push_back(exp);
  endtask

  task automatic drain();
    string       tag;
    int          sig;
    logic [15:0] exp, obs;
    while (q_tag.size() > 0) begin
      tag = q_tag.pop_front();
      sig = q_sig.pop_front();
      exp = q_exp.pop_front();
      obs = observe(sig);
      n_vec++;
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  task automatic kill(input int n, input bit counted);
    repeat (n) begin
      killed = 1'b1;
      step();
      killed = 1'b0;
      step();
      if (counted) m_score++;
    end
  endtask

  task automatic press_start();
    start = 1'b1;
    step();
    start = 1'b0;
    m_score = 0;
  endtask

  // Enemy 2 reaches the player line; gameover must follow exactly 2 clocks later.
  task automatic breach(input string tag);
    enemy_alive = 8'h04;
    enemy_y[2]  = 9'd440;
    step();
    push({tag, "_lat1_over"}, SIG_OVER, 16'd0);
    drain();
    enemy_alive = 8'h00;
    enemy_y[2]  = 9'd0;
    step();
    push({tag, "_over"}, SIG_OVER, 16'd1);
    push({tag, "_play"}, SIG_PLAY, 16'd0);
    push({tag, "_score"}, SIG_SCORE, to_bcd(m_score));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; killed = 1'b0; enemy_alive = 8'h00;
    for (int i = 0; i < 8; i++) enemy_y[i] = 9'd0;

    // 1: reset state
    step(2);
    push("rst_over", SIG_OVER, 16'd0);
    push("rst_play", SIG_PLAY, 16'd0);
    push("rst_score", SIG_SCORE, 16'h0000);
    push("rst_hi", SIG_HI, 16'h0000);
    push("rst_rec", SIG_REC, 16'd0);
    drain();
    reset = 1'b0;

    // 2: kills before start are ignored, then three counted kills
    kill(2, 1'b0);
    push("idle_kill_score", SIG_SCORE, 16'h0000);
    drain();
    press_start();
    push("start_play", SIG_PLAY, 16'd1);
    drain();
    kill(3, 1'b1);
    push("kill3_score", SIG_SCORE, 16'h0003);
    drain();

    // 4: dead slot at the bottom never ends the game
    enemy_alive = 8'h00;
    enemy_y[2]  = 9'd479;
    step(3);
    push("dead_slot_over", SIG_OVER, 16'd0);
    push("dead_slot_play", SIG_PLAY, 16'd1);
    drain();
    breach("breach1");
    push("breach1_hi", SIG_HI, HI_EN ? 16'h0003 : 16'h0000);
    push("breach1_rec", SIG_REC, {15'd0, HI_EN});
    drain();
    kill(2, 1'b0);
    push("over_kill_score", SIG_SCORE, 16'h0003);
    push("over_held", SIG_OVER, 16'd1);
    drain();

    // 3: BCD carry and saturation; start held through play must not re-clear
    press_start();
    push("restart_score", SIG_SCORE, 16'h0000);
    push("restart_rec", SIG_REC, 16'd0);
    push("restart_over", SIG_OVER, 16'd0);
    drain();
    kill(9, 1'b1);
    push("score9", SIG_SCORE, 16'h0009);
    drain();
    kill(1, 1'b1);
    push("score10", SIG_SCORE, 16'h0010);
    drain();
    killed = 1'b1;
    start  = 1'b1;
    step(9989);
    killed = 1'b0;
    start  = 1'b0;
    m_score += 9989;
    step();
    push("score9999", SIG_SCORE, 16'h9999);
    drain();
    kill(1, 1'b1);
    push("saturate", SIG_SCORE, to_bcd(m_score));
    drain();
    breach("breach2");
    push("breach2_hi", SIG_HI, HI_EN ? 16'h9999 : 16'h0000);
    drain();

    // reset clears hi_score too
    reset = 1'b1;
    step();
    reset = 1'b0;
    push("rst2_hi", SIG_HI, 16'h0000);
    push("rst2_over", SIG_OVER, 16'd0);
    drain();

    // 5: best-score tracking across three games
    press_start();
    kill(5, 1'b1);
    breach("game1");
    push("game1_hi", SIG_HI, HI_EN ? 16'h0005 : 16'h0000);
    push("game1_rec", SIG_REC, {15'd0, HI_EN});
    drain();
    press_start();
    push("game2_start_score", SIG_SCORE, 16'h0000);
    push("game2_start_rec", SIG_REC, 16'd0);
    drain();
    kill(3, 1'b1);
    breach("game2");
    push("game2_hi", SIG_HI, HI_EN ? 16'h0005 : 16'h0000);
    push("game2_rec", SIG_REC, 16'd0);
    drain();
    press_start();
    kill(5, 1'b1);
    breach("game3");
    push("game3_hi", SIG_HI, HI_EN ? 16'h0005 : 16'h0000);
    push("game3_rec", SIG_REC, 16'd0);
    drain();

    // 6: kill on the same edge that enters S_OVER is counted
    press_start();
    kill(7, 1'b1);
    enemy_alive = 8'h04;
    enemy_y[2]  = 9'd450;
    step();
    enemy_alive = 8'h00;
    killed      = 1'b1;
    step();
    killed = 1'b0;
    m_score++;
    push("same_edge_over", SIG_OVER, 16'd1);
    push("same_edge_score", SIG_SCORE, 16'h0008);
    push("same_edge_hi", SIG_HI, HI_EN ? 16'h0008 : 16'h0000);
    push("same_edge_rec", SIG_REC, {15'd0, HI_EN});
    drain();

    // reset in the middle of a game
    press_start();
    kill(2, 1'b1);
    push("midgame_score", SIG_SCORE, 16'h0002);
    drain();
    reset = 1'b1;
    step();
    reset = 1'b0;
    push("midrst_play", SIG_PLAY, 16'd0);
    push("midrst_over", SIG_OVER, 16'd0);
    push("midrst_score", SIG_SCORE, 16'h0000);
    push("midrst_hi", SIG_HI, 16'h0000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
